// File: rtl/pe_multibank_accfifo_if.sv
// Bus bundle for pe_multibank_accfifo.
// The master drives the compute/drain strobes and the FIR partial sum.
// The slave (the FIFO) returns the drain data, occupancy and status flags.
//   fir_in, acc_valid, add_zero, recirc, clear_push, swap, drain_rd : master -> slave
//   drain_data, drain_valid, drain_empty, swap_ready,
//   compute_cnt, compute_bank_id, ovf_flag, err_flag                 : slave -> master
interface pe_multibank_accfifo_if #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NB_BANKS = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned BW = $clog2(NB_BANKS);

   logic [DATA_W-1:0] fir_in;
   logic              acc_valid;
   logic              add_zero;
   logic              recirc;
   logic              clear_push;
   logic              swap;
   logic              drain_rd;
   logic [DATA_W-1:0] drain_data;
   logic              drain_valid;
   logic              drain_empty;
   logic              swap_ready;
   logic [CW-1:0]     compute_cnt;
   logic [BW-1:0]     compute_bank_id;
   logic              ovf_flag;
   logic              err_flag;

   modport master (
      output fir_in, acc_valid, add_zero, recirc, clear_push, swap, drain_rd,
      input  drain_data, drain_valid, drain_empty, swap_ready, compute_cnt,
             compute_bank_id, ovf_flag, err_flag
   );

   modport slave (
      input  fir_in, acc_valid, add_zero, recirc, clear_push, swap, drain_rd,
      output drain_data, drain_valid, drain_empty, swap_ready, compute_cnt,
             compute_bank_id, ovf_flag, err_flag
   );
endinterface

// File: rtl/pe_multibank_accfifo.sv
// N-bank accumulation FIFO for the PE partial-sum path.
// Bank C (compute) takes FIR partial sums: push, read-modify-write accumulate, recirculate and
// zero-fill. The other banks form a ring that drains through bank pointer D toward the
// out_to_right_PE chain. A swap rotates C forward once the next bank has fully drained.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : pe_multibank_accfifo_if slave (compute/drain strobes in, drain data and status out)
module pe_multibank_accfifo #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NB_BANKS = 2,
   parameter bit          SAT_EN   = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   pe_multibank_accfifo_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(NB_BANKS);

   typedef logic [BW-1:0] bank_t;

   localparam bank_t             LastBank = bank_t'(NB_BANKS - 1);
   localparam logic [CW-1:0]     FullCnt  = CW'(DEPTH);
   localparam logic [DATA_W-1:0] SatMax   = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SatMin   = {1'b1, {(DATA_W-1){1'b0}}};

   function automatic bank_t next_bank(input bank_t b);
      return (b == LastBank) ? '0 : bank_t'(b + 1'b1);
   endfunction

   // Storage and per-bank bookkeeping
   logic [DATA_W-1:0] mem_q    [NB_BANKS][DEPTH];
   logic [AW-1:0]     rd_ptr_q [NB_BANKS];
   logic [AW-1:0]     rd_ptr_d [NB_BANKS];
   logic [AW-1:0]     wr_ptr_q [NB_BANKS];
   logic [AW-1:0]     wr_ptr_d [NB_BANKS];
   logic [CW-1:0]     cnt_q    [NB_BANKS];
   logic [CW-1:0]     cnt_d    [NB_BANKS];

   bank_t             c_q, c_d, d_q, d_d;
   logic [DATA_W-1:0] drain_data_q, drain_data_d;
   logic              drain_valid_q, drain_valid_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;

   bank_t             c_next;
   logic [DATA_W-1:0] head;
   logic [DATA_W:0]   sum_ext;
   logic              sum_ovf;
   logic [DATA_W-1:0] acc_res;
   logic              c_empty, c_full, op_multi;
   logic              drain_empty, swap_ready;
   logic              push_en, pop_en;
   logic [DATA_W-1:0] push_val;

   assign c_next  = next_bank(c_q);
   assign head    = mem_q[c_q][rd_ptr_q[c_q]];
   assign c_empty = (cnt_q[c_q] == '0);
   assign c_full  = (cnt_q[c_q] == FullCnt);
   assign op_multi = ($countones({bus.acc_valid, bus.recirc, bus.clear_push}) > 1);

   // Sign-extended add: overflow when the two top bits of the DATA_W+1 result disagree
   assign sum_ext = {head[DATA_W-1], head} + {bus.fir_in[DATA_W-1], bus.fir_in};
   assign sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];

   always_comb begin
      acc_res = sum_ext[DATA_W-1:0];
      if (sum_ovf && SAT_EN) begin
         acc_res = sum_ext[DATA_W] ? SatMin : SatMax;
      end
   end

   // Both flags use pre-update counts, so a swap alongside the last drain of C+1 is rejected
   assign drain_empty = (d_q == c_q) || (cnt_q[d_q] == '0);
   assign swap_ready  = (cnt_q[c_next] == '0);

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      cnt_d         = cnt_q;
      c_d           = c_q;
      d_d           = d_q;
      drain_data_d  = drain_data_q;
      drain_valid_d = 1'b0;
      ovf_d         = ovf_q;
      err_d         = err_q;
      push_en       = 1'b0;
      pop_en        = 1'b0;
      push_val      = '0;

      // Compute bank operations
      if (op_multi) begin
         err_d = 1'b1;
      end else if (bus.acc_valid) begin
         if (bus.add_zero) begin
            if (c_full) begin
               err_d = 1'b1;
            end else begin
               push_en  = 1'b1;
               push_val = bus.fir_in;
            end
         end else if (c_empty) begin
            err_d = 1'b1;
         end else begin
            pop_en   = 1'b1;
            push_en  = 1'b1;
            push_val = acc_res;
            if (sum_ovf) ovf_d = 1'b1;
         end
      end else if (bus.recirc) begin
         if (c_empty) begin
            err_d = 1'b1;
         end else begin
            pop_en   = 1'b1;
            push_en  = 1'b1;
            push_val = head;
         end
      end else if (bus.clear_push) begin
         if (c_full) begin
            err_d = 1'b1;
         end else begin
            push_en = 1'b1;
         end
      end

      if (push_en) wr_ptr_d[c_q] = wr_ptr_q[c_q] + 1'b1;
      if (pop_en)  rd_ptr_d[c_q] = rd_ptr_q[c_q] + 1'b1;
      if (push_en && !pop_en) cnt_d[c_q] = cnt_q[c_q] + 1'b1;

      // Drain side: D never equals C when a pop happens, so it never collides with compute
      if (bus.drain_rd) begin
         if (drain_empty) begin
            err_d = 1'b1;
         end else begin
            drain_valid_d = 1'b1;
            drain_data_d  = mem_q[d_q][rd_ptr_q[d_q]];
            rd_ptr_d[d_q] = rd_ptr_q[d_q] + 1'b1;
            cnt_d[d_q]    = cnt_q[d_q] - 1'b1;
         end
      end

      // Skip over empty banks behind C; stop once D catches up with C
      if ((cnt_q[d_q] == '0) && (d_q != c_q)) begin
         d_d = next_bank(d_q);
      end

      if (bus.swap) begin
         if (swap_ready) begin
            c_d = c_next;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB_BANKS; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         c_q           <= '0;
         d_q           <= '0;
         drain_data_q  <= '0;
         drain_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cnt_q         <= cnt_d;
         c_q           <= c_d;
         d_q           <= d_d;
         drain_data_q  <= drain_data_d;
         drain_valid_q <= drain_valid_d;
         ovf_q         <= ovf_d;
         err_q         <= err_d;
      end
   end

   // Array contents are meaningless after reset (counts are zero), so no reset here
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[c_q][wr_ptr_q[c_q]] <= push_val;
      end
   end

   assign bus.drain_data      = drain_data_q;
   assign bus.drain_valid     = drain_valid_q;
   assign bus.drain_empty     = drain_empty;
   assign bus.swap_ready      = swap_ready;
   assign bus.compute_cnt     = cnt_q[c_q];
   assign bus.compute_bank_id = c_q;
   assign bus.ovf_flag        = ovf_q;
   assign bus.err_flag        = err_q;
endmodule
